imem_fill_resp: RTL and testbench
=================================

// Module: imem_fill_resp
// PURPOSE
//  L2-side responder for L1 I-cache line fills. Serves {b_rd_i, b_addr_i} requests by fetching
//  BEATS = LINE/BEAT consecutive beats from the backing memory port and assembling one line.
//  Returns the line on b_data_i with a one-cycle b_dv_i pulse.
//  Holds the last filled line in a one-entry buffer, so a repeated block address is answered without memory traffic.
// PARAMETERS
//  LINE     256  line width in bits (== imem IMEM_LINE); multiple of BEAT
//  BEAT     64   memory beat width in bits; power of two, >= 8
//  BLK_LEN  59   line address width (64 - log2(LINE/8))
// PORTS
//  clk      in   1         clock, rising edge
//  rst      in   1         asynchronous active-high reset
//  b_addr_i in   BLK_LEN   requested line address from I-cache
//  b_rd_i   in   1         request level; held high by I-cache until b_dv_i seen
//  b_data_i out  LINE      returned line; beat k at bits [k*BEAT +: BEAT]
//  b_dv_i   out  1         line valid, single-cycle pulse
//  inv      in   1         invalidate line buffer (fence.i / external write)
//  m_req    out  1         memory beat request
//  m_addr   out  64        byte address of beat: {blk, beat_idx, log2(BEAT/8) zeros}
//  m_gnt    in   1         request accepted this cycle (m_req && m_gnt = handshake)
//  m_rdata  in   BEAT      read beat data
//  m_rvalid in   1         m_rdata valid; responses return in request order
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, b_dv_i=0, b_data_i=0, m_req=0, m_addr=0.
//    Reset also clears buf_v, issue/return counters and blk.
//  The I-cache registers b_addr_i one cycle after raising b_rd_i.
//    Therefore the address is sampled only in ADDR, the 2nd cycle of b_rd_i high.
//  FSM:
//   IDLE : b_rd_i=1 -> ADDR.
//   ADDR : blk<=b_addr_i.
//          Hit = buf_v && buf_blk==b_addr_i && !inv; on hit -> DONE.
//          Otherwise clear counters, buf_v<=0, -> FILL.
//   FILL : m_req=1 while issued<BEATS; m_addr=beat issued; issued++ on m_req&&m_gnt.
//          On each m_rvalid, write m_rdata to beat slot returned and increment returned.
//          Once returned==BEATS: buf_blk<=blk, buf_v<=1, -> DONE.
//          An m_rvalid with returned==BEATS (protocol error) is ignored.
//   DONE : b_dv_i=1 for exactly this cycle; b_data_i=line buffer -> GAP.
//   GAP  : one dead cycle (I-cache drops b_rd_i here); ignore b_rd_i -> IDLE.
//  b_data_i is registered and stable from DONE until the next FILL writes a beat.
//    It is driven directly from the line buffer.
//  Latency from b_rd_i rising (cycle 0): buffer hit -> b_dv_i at cycle 2.
//    Miss with zero-wait memory (m_gnt=1, m_rvalid 1 cycle after grant) -> b_dv_i at cycle 2+BEATS+1.
//  Multiple beats may be outstanding; counters are log2(BEATS)+1 bits wide and do not wrap.
//  The in-flight line is never exposed until complete.
//  inv: clears buf_v in any state except the FILL completion cycle.
//    In that cycle (inv with returned reaching BEATS), inv wins: line is returned, buf_v stays 0.
//  inv during FILL: the in-progress fill still completes and b_dv_i still pulses; buf_v ends 0.
//  b_rd_i dropping mid-FILL: the fill completes and the pulse is still issued (I-cache never does this).
//  b_rd_i low in ADDR: return to IDLE, no memory traffic.
//  Reset mid-FILL: outstanding memory responses after reset deassertion are ignored (state IDLE).
// TESTING
//  1 Cold miss blk=0x10, BEAT=64, m_gnt=1, 1-cycle m_rvalid -> m_addr 0x200,0x208,0x210,0x218.
//    b_dv_i at cycle 7; b_data_i={d3,d2,d1,d0}.
//  2 Repeat blk=0x10 -> no m_req; b_dv_i at cycle 2 with same line.
//  3 Repeat with inv=1 in ADDR cycle -> full refetch of 4 beats; buf_v=0 at DONE if inv held.
//  4 m_gnt toggling 1/0 and m_rvalid delays 0..5 -> exactly 4 grants, one b_dv_i, beats in order.
//  5 rst pulse mid-FILL after 2 beats; stale m_rvalid after reset -> state IDLE, no b_dv_i.
//    Next request to 0x10 misses.
//  6 Back-to-back requests 0x10, 0x11 (b_rd_i re-raised after GAP) -> two pulses; 2nd line from 0x220..0x238.

Source files
------------

// File: rtl/imem_fill_resp_if.sv
// Request/response bundle between the I-cache, the fill responder and the backing memory port.
// The master modport is the I-cache plus memory side; the slave modport is the responder.
interface imem_fill_resp_if #(
    parameter int LINE    = 256,
    parameter int BEAT    = 64,
    parameter int BLK_LEN = 59
);
    logic [BLK_LEN-1:0] b_addr_i;
    logic               b_rd_i;
    logic [LINE-1:0]    b_data_i;
    logic               b_dv_i;
    logic               inv;
    logic               m_req;
    logic [63:0]        m_addr;
    logic               m_gnt;
    logic [BEAT-1:0]    m_rdata;
    logic               m_rvalid;

    modport master (
        output b_addr_i, b_rd_i, inv, m_gnt, m_rdata, m_rvalid,
        input  b_data_i, b_dv_i, m_req, m_addr
    );

    modport slave (
        input  b_addr_i, b_rd_i, inv, m_gnt, m_rdata, m_rvalid,
        output b_data_i, b_dv_i, m_req, m_addr
    );
endinterface

// File: rtl/imem_fill_resp.sv
// L2-side I-cache line-fill responder with a one-entry line buffer; hit answers at cycle 2,
// a miss after BEATS beat fetches. Memory backpressure via m_gnt; several beats may be outstanding.
module imem_fill_resp #(
    parameter int LINE    = 256,
    parameter int BEAT    = 64,
    parameter int BLK_LEN = 59
) (
    input  logic              clk,
    input  logic              rst,
    imem_fill_resp_if.slave   bus
);
    localparam int BEATS  = LINE / BEAT;
    localparam int CW     = $clog2(BEATS) + 1;
    localparam int OFF    = $clog2(BEAT / 8);
    localparam int BLK_SH = $clog2(LINE / 8);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FILL, S_DONE, S_GAP} state_t;

    state_t             state_q;
    logic [BLK_LEN-1:0] blk_q;
    logic [BLK_LEN-1:0] buf_blk_q;
    logic               buf_v_q;
    logic [CW-1:0]      issued_q;
    logic [CW-1:0]      returned_q;
    logic [LINE-1:0]    line_q;
    logic               b_dv_q;
    logic               m_req_q;
    logic [63:0]        m_addr_q;

    logic [CW-1:0]      issued_d;
    logic               ret_v;
    logic               fill_done;
    logic               hit;

    function automatic logic [63:0] beat_addr(input logic [BLK_LEN-1:0] b, input logic [CW-1:0] idx);
        return (64'(b) << BLK_SH) | (64'(idx) << OFF);
    endfunction

    always_comb begin
        issued_d  = issued_q + CW'(m_req_q & bus.m_gnt);
        ret_v     = (state_q == S_FILL) && bus.m_rvalid && (returned_q < CW'(BEATS));
        fill_done = ret_v && (returned_q == CW'(BEATS - 1));
        hit       = buf_v_q && (buf_blk_q == bus.b_addr_i) && !bus.inv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            blk_q      <= '0;
            buf_blk_q  <= '0;
            buf_v_q    <= 1'b0;
            issued_q   <= '0;
            returned_q <= '0;
            line_q     <= '0;
            b_dv_q     <= 1'b0;
            m_req_q    <= 1'b0;
            m_addr_q   <= '0;
        end else begin
            b_dv_q <= 1'b0;
            if (bus.inv) buf_v_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.b_rd_i) state_q <= S_ADDR;
                end
                S_ADDR: begin
                    if (!bus.b_rd_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        blk_q <= bus.b_addr_i;
                        if (hit) begin
                            b_dv_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            issued_q   <= '0;
                            returned_q <= '0;
                            buf_v_q    <= 1'b0;
                            m_req_q    <= 1'b1;
                            m_addr_q   <= beat_addr(bus.b_addr_i, '0);
                            state_q    <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    issued_q <= issued_d;
                    m_req_q  <= (issued_d < CW'(BEATS));
                    if (issued_d < CW'(BEATS)) m_addr_q <= beat_addr(blk_q, issued_d);
                    if (ret_v) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (returned_q == CW'(k)) line_q[k*BEAT +: BEAT] <= bus.m_rdata;
                        end
                        returned_q <= returned_q + CW'(1);
                    end
                    // An invalidate landing on the completing beat keeps the buffer invalid.
                    if (fill_done) begin
                        buf_blk_q <= blk_q;
                        buf_v_q   <= !bus.inv;
                        b_dv_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_GAP;
                S_GAP:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.b_data_i = line_q;
    assign bus.b_dv_i   = b_dv_q;
    assign bus.m_req    = m_req_q;
    assign bus.m_addr   = m_addr_q;
endmodule

// File: tb/tb_imem_fill_resp.sv
// Directed bench for imem_fill_resp: I-cache request driver plus an in-order memory model
// with configurable grant pattern and per-beat response delay.
module tb_imem_fill_resp;
    localparam logic [255:0] L10 = 256'hC0DE0218_00000218_C0DE0210_00000210_C0DE0208_00000208_C0DE0200_00000200;
    localparam logic [255:0] L11 = 256'hC0DE0238_00000238_C0DE0230_00000230_C0DE0228_00000228_C0DE0220_00000220;
    localparam logic [255:0] L12 = 256'hC0DE0258_00000258_C0DE0250_00000250_C0DE0248_00000248_C0DE0240_00000240;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   g_cnt = 0;
    int   dv_cnt = 0;
    bit   gmode = 1'b0;
    bit   tog = 1'b1;
    int   dly [4] = '{1, 1, 1, 1};
    logic [63:0] pend_a [$];
    int          pend_t [$];
    logic [63:0] gaddr  [$];

    imem_fill_resp_if bus ();

    imem_fill_resp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bus.b_dv_i) dv_cnt++;

    function automatic logic [63:0] mdat(input logic [63:0] a);
        return {16'hC0DE, a[15:0], a[31:0]};
    endfunction

    // In-order memory: grants per gmode, each response ready dly[] cycles after its grant.
    always @(negedge clk) begin
        if (gmode) tog = ~tog;
        else       tog = 1'b1;
        bus.m_gnt = tog;
        if (bus.m_req && bus.m_gnt) begin
            pend_a.push_back(bus.m_addr);
            pend_t.push_back(cyc + dly[g_cnt % 4]);
            gaddr.push_back(bus.m_addr);
            g_cnt++;
        end
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        if (pend_a.size() != 0 && pend_t[0] <= cyc) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = mdat(pend_a.pop_front());
            void'(pend_t.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        while (pend_a.size() != 0 && w < 50) begin
            step();
            w++;
        end
    endtask

    task automatic check_addrs(input string tag, input logic [63:0] base);
        chk({tag, "_naddr"}, 256'(gaddr.size()), 256'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), (i < gaddr.size()) ? gaddr[i] : 64'd0,
                base + 64'(8 * i));
        end
    endtask

    task automatic do_req(input string tag, input logic [58:0] blk, input bit inv_hold,
                          output int lat, output int ng, output logic [255:0] line);
        int g0;
        int d0;
        int t0;
        bit seen;
        drain();
        gaddr.delete();
        g0 = g_cnt;
        d0 = dv_cnt;
        step();
        bus.b_rd_i   = 1'b1;
        bus.b_addr_i = ~blk;
        t0 = cyc;
        step();
        bus.b_addr_i = blk;
        bus.inv      = inv_hold;
        seen = 1'b0;
        lat  = -1;
        line = '0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step();
            if (bus.b_dv_i) begin
                seen = 1'b1;
                lat  = cyc - t0;
                line = bus.b_data_i;
            end
        end
        chk({tag, "_dv_seen"}, 256'(seen), 256'd1);
        bus.inv = 1'b0;
        step();
        bus.b_rd_i = 1'b0;
        chk({tag, "_dv_single"}, 256'(bus.b_dv_i), 256'd0);
        chk({tag, "_dv_count"}, 256'(dv_cnt - d0), 256'd1);
        ng = g_cnt - g0;
    endtask

    initial begin
        int lat;
        int ng;
        int g0;
        int d0;
        int t0;
        logic [255:0] line;

        rst          = 1'b1;
        bus.b_rd_i   = 1'b0;
        bus.b_addr_i = '0;
        bus.inv      = 1'b0;
        repeat (2) step();
        chk("rst_dv", 256'(bus.b_dv_i), 256'd0);
        chk("rst_mreq", 256'(bus.m_req), 256'd0);
        chk("rst_maddr", 256'(bus.m_addr), 256'd0);
        chk("rst_data", bus.b_data_i, 256'd0);
        rst = 1'b0;

        // b_rd_i dropped in ADDR: no traffic, no pulse
        step();
        g0 = g_cnt;
        d0 = dv_cnt;
        bus.b_rd_i = 1'b1;
        step();
        bus.b_rd_i = 1'b0;
        repeat (6) step();
        chk("abort_gnt", 256'(g_cnt - g0), 256'd0);
        chk("abort_dv", 256'(dv_cnt - d0), 256'd0);

        // 1: cold miss
        do_req("t1", 59'h10, 1'b0, lat, ng, line);
        chk("t1_lat", 256'(lat), 256'd7);
        chk("t1_ngnt", 256'(ng), 256'd4);
        chk("t1_line", line, L10);
        check_addrs("t1", 64'h200);

        // 2: buffer hit
        do_req("t2", 59'h10, 1'b0, lat, ng, line);
        chk("t2_lat", 256'(lat), 256'd2);
        chk("t2_ngnt", 256'(ng), 256'd0);
        chk("t2_line", line, L10);

        // 3: inv held through the request forces refetch and leaves the buffer invalid
        do_req("t3a", 59'h10, 1'b1, lat, ng, line);
        chk("t3a_lat", 256'(lat), 256'd7);
        chk("t3a_ngnt", 256'(ng), 256'd4);
        chk("t3a_line", line, L10);
        check_addrs("t3a", 64'h200);
        do_req("t3b", 59'h10, 1'b0, lat, ng, line);
        chk("t3b_lat", 256'(lat), 256'd7);
        chk("t3b_ngnt", 256'(ng), 256'd4);
        do_req("t3c", 59'h10, 1'b0, lat, ng, line);
        chk("t3c_lat", 256'(lat), 256'd2);
        chk("t3c_ngnt", 256'(ng), 256'd0);

        // 6: back-to-back requests
        do_req("t6a", 59'h10, 1'b0, lat, ng, line);
        chk("t6a_lat", 256'(lat), 256'd2);
        do_req("t6b", 59'h11, 1'b0, lat, ng, line);
        chk("t6b_lat", 256'(lat), 256'd7);
        chk("t6b_ngnt", 256'(ng), 256'd4);
        chk("t6b_line", line, L11);
        check_addrs("t6b", 64'h220);

        // 4: toggling grant, mixed response delays
        gmode = 1'b1;
        dly   = '{0, 5, 2, 3};
        do_req("t4", 59'h12, 1'b0, lat, ng, line);
        chk("t4_ngnt", 256'(ng), 256'd4);
        chk("t4_line", line, L12);
        check_addrs("t4", 64'h240);
        gmode = 1'b0;
        drain();

        // 5: reset after two returned beats, two responses still in flight
        dly = '{3, 3, 3, 3};
        gaddr.delete();
        g0 = g_cnt;
        d0 = dv_cnt;
        step();
        bus.b_rd_i   = 1'b1;
        bus.b_addr_i = 59'h3;
        t0 = cyc;
        step();
        bus.b_addr_i = 59'h10;
        for (int i = 0; i < 20 && cyc < t0 + 7; i++) step();
        rst        = 1'b1;
        bus.b_rd_i = 1'b0;
        #1;
        chk("t5_rst_dv", 256'(bus.b_dv_i), 256'd0);
        chk("t5_rst_mreq", 256'(bus.m_req), 256'd0);
        chk("t5_rst_data", bus.b_data_i, 256'd0);
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("t5_no_dv", 256'(dv_cnt - d0), 256'd0);
        chk("t5_ngnt", 256'(g_cnt - g0), 256'd4);
        chk("t5_stale_data", bus.b_data_i, 256'd0);
        dly = '{1, 1, 1, 1};
        do_req("t5r", 59'h10, 1'b0, lat, ng, line);
        chk("t5r_lat", 256'(lat), 256'd7);
        chk("t5r_ngnt", 256'(ng), 256'd4);
        chk("t5r_line", line, L10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
